ball_motion: RTL and testbench

//  Motion/integration end of the hit-controller interface. Holds one ball's position and velocity.

---
 rtl/billiard_pkg.sv | 22 ++
 rtl/ball_motion_friction_decay.sv | 27 ++
 rtl/ball_motion.sv | 141 ++++++++++++++
 tb/tb_ball_motion.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/billiard_pkg.sv
`default_nettype none
// ============================================================================
// billiard_pkg : shared types and constants for the ball motion slice
// Rev 1.0
// ============================================================================
package billiard_pkg;

    localparam int BALL_SIZE = 32;
    localparam int FRAC_BITS = 6;
    localparam int POS_W     = 17;
    localparam int VEL_W     = 11;

    typedef logic signed [VEL_W-1:0] vel_t;
    typedef logic signed [POS_W-1:0] pos_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        MOVING = 1'b1
    } motion_state_t;

endpackage
`default_nettype wire

// File: rtl/ball_motion_friction_decay.sv
`default_nettype none
// ============================================================================
// friction_decay : moves a velocity toward zero by STEP, saturating at zero
// Rev 1.0
// ============================================================================
module friction_decay
    import billiard_pkg::*;
#(
    parameter int STEP = 1
) (
    input  vel_t vel_i,
    output vel_t vel_o
);

    localparam vel_t C_STEP = vel_t'(STEP);

    always_comb begin
        vel_o = '0;
        if (vel_i > C_STEP) begin
            vel_o = vel_i - C_STEP;
        end else if (vel_i < -C_STEP) begin
            vel_o = vel_i + C_STEP;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ball_motion.sv
`default_nettype none
// ============================================================================
// ball_motion : position/velocity integrator for one ball (strike, friction,
//               collision bounce, border clamp)
// Rev 1.0
// ============================================================================
module ball_motion
    import billiard_pkg::*;
#(
    parameter int INIT_X          = 100,
    parameter int INIT_Y          = 200,
    parameter int LEFT_BOUND      = 32,
    parameter int RIGHT_BOUND     = 608,
    parameter int TOP_BOUND       = 32,
    parameter int DOWN_BOUND      = 448,
    parameter int FRICTION_PERIOD = 4,
    parameter int FRICTION_STEP   = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        hitReq,
    input  vel_t        hitVelX,
    input  vel_t        hitVelY,
    input  logic        collisionOccurred,
    input  vel_t        collVelX,
    input  vel_t        collVelY,
    output vel_t        ballTopLeftPosX,
    output vel_t        ballTopLeftPosY,
    output vel_t        ballVelX,
    output vel_t        ballVelY,
    output logic        ballMoving
);

    localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FRICTION_PERIOD - 1);

    localparam logic signed [POS_W:0] C_XMIN = (POS_W+1)'(LEFT_BOUND <<< FRAC_BITS);
    localparam logic signed [POS_W:0] C_XMAX = (POS_W+1)'((RIGHT_BOUND - BALL_SIZE) <<< FRAC_BITS);
    localparam logic signed [POS_W:0] C_YMIN = (POS_W+1)'(TOP_BOUND <<< FRAC_BITS);
    localparam logic signed [POS_W:0] C_YMAX = (POS_W+1)'((DOWN_BOUND - BALL_SIZE) <<< FRAC_BITS);

    motion_state_t    state_q;
    pos_t             posX_q, posY_q;
    vel_t             velX_q, velY_q;
    vel_t             outPosX_q, outPosY_q;
    logic             moving_q;
    logic [CNT_W-1:0] fricCnt_q;

    // A bounce is only accepted when it exactly reverses a live axis; this
    // filters the stale value the collision block presents on the unhit axis.
    logic signed [VEL_W:0] negVelX, negVelY;
    logic                  accX, accY;
    vel_t                  collX, collY;
    vel_t                  decX, decY;
    logic                  fricStep;
    vel_t                  velX_d, velY_d;
    logic signed [POS_W:0] sumX, sumY;
    pos_t                  posX_d, posY_d;

    assign negVelX = -((VEL_W+1)'(velX_q));
    assign negVelY = -((VEL_W+1)'(velY_q));
    assign accX    = collisionOccurred && (velX_q != '0) && ((VEL_W+1)'(collVelX) == negVelX);
    assign accY    = collisionOccurred && (velY_q != '0) && ((VEL_W+1)'(collVelY) == negVelY);
    assign collX   = accX ? collVelX : velX_q;
    assign collY   = accY ? collVelY : velY_q;

    friction_decay #(.STEP(FRICTION_STEP)) u_decay_x (.vel_i(collX), .vel_o(decX));
    friction_decay #(.STEP(FRICTION_STEP)) u_decay_y (.vel_i(collY), .vel_o(decY));

    assign fricStep = (fricCnt_q == C_CNT_LAST);
    assign velX_d   = fricStep ? decX : collX;
    assign velY_d   = fricStep ? decY : collY;

    assign sumX = (POS_W+1)'(posX_q) + (POS_W+1)'(velX_d);
    assign sumY = (POS_W+1)'(posY_q) + (POS_W+1)'(velY_d);

    always_comb begin
        posX_d = pos_t'(sumX);
        if (sumX < C_XMIN) posX_d = pos_t'(C_XMIN);
        else if (sumX > C_XMAX) posX_d = pos_t'(C_XMAX);
        posY_d = pos_t'(sumY);
        if (sumY < C_YMIN) posY_d = pos_t'(C_YMIN);
        else if (sumY > C_YMAX) posY_d = pos_t'(C_YMAX);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= IDLE;
            posX_q    <= pos_t'(INIT_X <<< FRAC_BITS);
            posY_q    <= pos_t'(INIT_Y <<< FRAC_BITS);
            outPosX_q <= vel_t'(INIT_X);
            outPosY_q <= vel_t'(INIT_Y);
            velX_q    <= '0;
            velY_q    <= '0;
            moving_q  <= 1'b0;
            fricCnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hitReq) begin
                        velX_q <= hitVelX;
                        velY_q <= hitVelY;
                        if ((hitVelX != '0) || (hitVelY != '0)) begin
                            state_q  <= MOVING;
                            moving_q <= 1'b1;
                        end
                    end
                end
                MOVING: begin
                    if (startOfFrame) begin
                        velX_q    <= velX_d;
                        velY_q    <= velY_d;
                        posX_q    <= posX_d;
                        posY_q    <= posY_d;
                        outPosX_q <= posX_d[POS_W-1:FRAC_BITS];
                        outPosY_q <= posY_d[POS_W-1:FRAC_BITS];
                        fricCnt_q <= fricStep ? '0 : fricCnt_q + 1'b1;
                        if ((velX_d == '0) && (velY_d == '0)) begin
                            state_q   <= IDLE;
                            moving_q  <= 1'b0;
                            fricCnt_q <= '0;
                        end
                    end else if (collisionOccurred) begin
                        velX_q <= collX;
                        velY_q <= collY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ballTopLeftPosX = outPosX_q;
    assign ballTopLeftPosY = outPosY_q;
    assign ballVelX        = velX_q;
    assign ballVelY        = velY_q;
    assign ballMoving      = moving_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
// ============================================================================
// tb_ball_motion : directed self-checking bench for ball_motion
// Rev 1.0
// ============================================================================
module tb_ball_motion;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               hitReq;
    logic signed [10:0] hitVelX, hitVelY;
    logic               collisionOccurred;
    logic signed [10:0] collVelX, collVelY;
    logic signed [10:0] posX, posY, velX, velY;
    logic               moving;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .hitReq            (hitReq),
        .hitVelX           (hitVelX),
        .hitVelY           (hitVelY),
        .collisionOccurred (collisionOccurred),
        .collVelX          (collVelX),
        .collVelY          (collVelY),
        .ballTopLeftPosX   (posX),
        .ballTopLeftPosY   (posY),
        .ballVelX          (velX),
        .ballVelY          (velY),
        .ballMoving        (moving)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic hit(input int x, input int y);
        hitVelX = 11'(x);
        hitVelY = 11'(y);
        hitReq  = 1'b1;
        @(negedge clk);
        hitReq  = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            @(negedge clk);
            startOfFrame = 1'b0;
        end
    endtask

    task automatic coll(input int x, input int y, input logic with_frame);
        collVelX          = 11'(x);
        collVelY          = 11'(y);
        collisionOccurred = 1'b1;
        startOfFrame      = with_frame;
        @(negedge clk);
        collisionOccurred = 1'b0;
        startOfFrame      = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; hitReq = 1'b0; collisionOccurred = 1'b0;
        hitVelX = '0; hitVelY = '0; collVelX = '0; collVelY = '0;
        @(negedge clk);

        // reset state
        do_reset();
        check_val("rst_posx", posX, 100);
        check_val("rst_posy", posY, 200);
        check_val("rst_velx", velX, 0);
        check_val("rst_vely", velY, 0);
        check_val("rst_moving", moving, 0);

        // zero-velocity strike stays idle
        hit(0, 0);
        check_val("zero_hit_moving", moving, 0);

        // strike then integrate; friction lands on the fourth frame
        hit(64, 0);
        check_val("hit_moving", moving, 1);
        check_val("hit_velx", velX, 64);
        frames(1);
        check_val("f1_posx", posX, 101);
        check_val("f1_posy", posY, 200);
        frames(3);
        check_val("f4_velx", velX, 63);
        check_val("f4_posx", posX, 103);
        check_val("f4_moving", moving, 1);

        // collision: X reverses, stale Y rejected; then the reverse case
        do_reset();
        hit(64, -32);
        coll(-64, 99, 1'b0);
        check_val("coll1_velx", velX, -64);
        check_val("coll1_vely", velY, -32);
        coll(99, 32, 1'b0);
        check_val("coll2_velx", velX, -64);
        check_val("coll2_vely", velY, 32);

        // friction drives tiny velocity to zero and stops on the same edge
        do_reset();
        hit(1, 0);
        frames(3);
        check_val("stop_pre_moving", moving, 1);
        frames(1);
        check_val("stop_velx", velX, 0);
        check_val("stop_moving", moving, 0);
        check_val("stop_posx", posX, 100);
        coll(-1, 0, 1'b0);
        check_val("idle_coll_velx", velX, 0);
        check_val("idle_coll_moving", moving, 0);

        // right border clamp, velocity untouched by clamp
        do_reset();
        hit(1023, 0);
        frames(40);
        check_val("clamp_r_posx", posX, 576);
        check_val("clamp_r_velx", velX, 1013);
        check_val("clamp_r_moving", moving, 1);

        // top border clamp with most-negative velocity
        do_reset();
        hit(0, -1024);
        frames(20);
        check_val("clamp_t_posy", posY, 32);
        check_val("clamp_t_vely", velY, -1019);
        check_val("clamp_t_posx", posX, 100);

        // collision and frame together, hit ignored while moving, reset mid-motion
        do_reset();
        hit(64, 0);
        frames(1);
        check_val("both_pre_posx", posX, 101);
        coll(-64, 0, 1'b1);
        check_val("both_posx", posX, 100);
        check_val("both_velx", velX, -64);
        hit(5, 5);
        check_val("mhit_velx", velX, -64);
        check_val("mhit_vely", velY, 0);
        check_val("mhit_moving", moving, 1);
        resetN = 1'b0;
        @(negedge clk);
        check_val("mrst_posx", posX, 100);
        check_val("mrst_posy", posY, 200);
        check_val("mrst_velx", velX, 0);
        check_val("mrst_moving", moving, 0);
        resetN = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
